apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  Converts single-shot processor requests (Processor_Bus master side) into APB transfers (APB_Bus master side).
//  Sits between the processor and the APB slaves.
//  Sequences SETUP/ACCESS phases, waits on slave ready, returns read data and completion.
//  Aborts with an error on an illegal select or a slave timeout.
// PARAMETERS
//  DATA_W       8   data width, processor and APB sides
//  ADDR_W       8   address width
//  SEL_W        2   slave select width; one-hot, one bit per slave
//  TIMEOUT      16  max ACCESS cycles awaiting apb_ready; 0 = never time out
// PORTS
//  clk              in   1       single clock, rising edge
//  reset            in   1       asynchronous, active-high
//  proc_start       in   1       request strobe; sampled only when proc_busy=0
//  proc_write       in   1       1=write, 0=read
//  proc_sel         in   SEL_W   target slave (one-hot)
//  proc_addr        in   ADDR_W  target address
//  proc_wdata       in   DATA_W  write data
//  proc_wait_cycles in   8       wait-cycle hint forwarded to slave
//  proc_rdata       out  DATA_W  read data; valid while proc_ready=1
//  proc_ready       out  1       1-cycle completion pulse
//  proc_error       out  1       qualifies proc_ready: illegal sel or timeout
//  proc_busy        out  1       1 while a transfer is in flight
//  apb_write        out  1       PWRITE
//  apb_sel          out  SEL_W   PSEL, one-hot
//  apb_addr         out  ADDR_W  PADDR
//  apb_wdata        out  DATA_W  PWDATA
//  apb_enable       out  1       PENABLE
//  apb_wait_cycles  out  8       forwarded wait hint
//  apb_ready        in   1       PREADY
//  apb_rdata        in   DATA_W  PRDATA
// BEHAVIOUR
//  - Reset (asynchronous, immediate, also mid-transfer): state=IDLE; every output =0; counter=0. No completion pulse for the aborted transfer.
//  - FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
//  - IDLE: proc_start=1 at a clk edge latches write/sel/addr/wdata/wait_cycles.
//    - Legal sel ($onehot): go to SETUP.
//    - Illegal sel (0 or >1 bit set): go to DONE with error=1. No APB activity.
//  - SETUP (1 cycle): apb_sel/addr/write/wdata/wait_cycles driven from latched values; apb_enable=0. Then ACCESS.
//  - ACCESS: apb_enable=1; all other APB outputs held stable.
//    - apb_ready=1 at an edge: capture apb_rdata for reads (0 for writes); go to DONE with error=0.
//    - Counter increments on each edge with apb_ready=0.
//    - Counter reaches TIMEOUT (TIMEOUT>0): go to DONE with error=1, rdata=0.
//    - apb_ready wins over timeout on the same edge.
//  - DONE (1 cycle): proc_ready=1, proc_error and proc_rdata valid. APB outputs return to 0 (sel=0, enable=0). Next state IDLE.
//  - proc_busy=1 in SETUP/ACCESS/DONE; 0 in IDLE. proc_start while busy is ignored; no queuing.
//  - Outside DONE: proc_rdata keeps its last value; proc_ready=0, proc_error=0.
//  - Latency, zero-wait slave: start edge N -> SETUP cycle N+1 -> ACCESS N+2 -> DONE/proc_ready N+3. Each slave wait cycle adds 1.
//  - Back-to-back: next start accepted in the IDLE cycle after DONE. Minimum 4 cycles per transfer.
//  - Counter width is $clog2(TIMEOUT+1). It saturates and never wraps. It clears on entry to SETUP.
// STRUCTURE
//  - apb_pkg: state enum apb_state_t {IDLE,SETUP,ACCESS,DONE}; DATA_W/ADDR_W/SEL_W default localparams.
//  - Sub-module apb_timeout_counter:
//    - inputs: clk, reset, clear, count_en
//    - output: expired
//    - parameter: TIMEOUT
//  - Everything else (FSM, request latch, output registers) is in apb_master_bridge.
// TESTING
//  1. Write, zero-wait: start, sel=01, addr=8'h10, wdata=8'hA5.
//     -> SETUP at +1 (sel=01, enable=0), ACCESS at +2; proc_ready at +3, error=0.
//  2. Read, 3 wait cycles: sel=10, addr=8'h22, slave drives rdata=8'h5C with ready on 4th ACCESS cycle.
//     -> proc_rdata=8'h5C, proc_ready at +6; APB outputs stable throughout ACCESS.
//  3. Timeout: TIMEOUT=4, slave never ready.
//     -> after 4 ACCESS cycles, DONE with proc_error=1, rdata=0, apb_sel=0.
//  4. Illegal sel=00 and sel=11.
//     -> proc_ready+error at +1; apb_sel/enable stay 0 throughout.
//  5. Reset asserted mid-ACCESS.
//     -> all outputs 0 asynchronously, no proc_ready; next start runs normally.
//  6. proc_start held high continuously.
//     -> transfers complete every 4 cycles; starts while busy are ignored.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default widths for the processor-to-APB bridge.
// No logic, so no latency and no backpressure of its own.
// Width and timeout defaults used by the bridge and its timeout counter.
package apb_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_SEL_W   = 2;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } apb_state_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS cycles without PREADY and flags the edge on which the count reaches TIMEOUT.
// expired is combinational from the current count, so the FSM can act on that same edge.
// No backpressure. The count saturates instead of wrapping. TIMEOUT=0 disables expiry.
module apb_timeout_counter
    import apb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit            ENABLED = (TIMEOUT > 0);
    localparam logic [CW-1:0] CMAX    = CW'(TIMEOUT);
    localparam logic [CW-1:0] CLAST   = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (ENABLED && count_en && (count != CMAX)) begin
            count <= count + CW'(1);
        end
    end

    // True when this edge's increment brings the count to TIMEOUT.
    assign expired = ENABLED && count_en && (count >= CLAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Turns single-shot processor requests into APB SETUP/ACCESS transfers and returns completion.
// Zero-wait latency: start edge N -> proc_ready in cycle N+3. Each slave wait cycle adds 1.
// The slave stalls the bridge through PREADY. proc_start is ignored while proc_busy=1. No queuing.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              proc_start,
    input  logic              proc_write,
    input  logic [SEL_W-1:0]  proc_sel,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [DATA_W-1:0] proc_wdata,
    input  logic [7:0]        proc_wait_cycles,
    output logic [DATA_W-1:0] proc_rdata,
    output logic              proc_ready,
    output logic              proc_error,
    output logic              proc_busy,
    output logic              apb_write,
    output logic [SEL_W-1:0]  apb_sel,
    output logic [ADDR_W-1:0] apb_addr,
    output logic [DATA_W-1:0] apb_wdata,
    output logic              apb_enable,
    output logic [7:0]        apb_wait_cycles,
    input  logic              apb_ready,
    input  logic [DATA_W-1:0] apb_rdata
);

    apb_state_t state;
    logic       legal_sel;
    logic       cnt_clear;
    logic       cnt_en;
    logic       expired;

    assign legal_sel = $onehot(proc_sel);
    assign cnt_clear = (state == IDLE) && proc_start && legal_sel;
    assign cnt_en    = (state == ACCESS) && !apb_ready;

    apb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .count_en (cnt_en),
        .expired  (expired)
    );

    // The APB address-phase registers double as the request latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            proc_rdata      <= '0;
            proc_ready      <= 1'b0;
            proc_error      <= 1'b0;
            proc_busy       <= 1'b0;
            apb_write       <= 1'b0;
            apb_sel         <= '0;
            apb_addr        <= '0;
            apb_wdata       <= '0;
            apb_enable      <= 1'b0;
            apb_wait_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (proc_start) begin
                        proc_busy <= 1'b1;
                        if (legal_sel) begin
                            state           <= SETUP;
                            apb_write       <= proc_write;
                            apb_sel         <= proc_sel;
                            apb_addr        <= proc_addr;
                            apb_wdata       <= proc_wdata;
                            apb_wait_cycles <= proc_wait_cycles;
                        end else begin
                            state      <= DONE;
                            proc_ready <= 1'b1;
                            proc_error <= 1'b1;
                            proc_rdata <= '0;
                        end
                    end
                end
                SETUP: begin
                    apb_enable <= 1'b1;
                    state      <= ACCESS;
                end
                ACCESS: begin
                    // PREADY takes priority over an expiry on the same edge.
                    if (apb_ready || expired) begin
                        state           <= DONE;
                        proc_ready      <= 1'b1;
                        proc_error      <= !apb_ready;
                        proc_rdata      <= (apb_ready && !apb_write) ? apb_rdata : '0;
                        apb_write       <= 1'b0;
                        apb_sel         <= '0;
                        apb_addr        <= '0;
                        apb_wdata       <= '0;
                        apb_enable      <= 1'b0;
                        apb_wait_cycles <= '0;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    proc_ready <= 1'b0;
                    proc_error <= 1'b0;
                    proc_busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge with TIMEOUT=4: directed vector table, reset and
// held-start sequences, then randomized transfers checked cycle by cycle against a transfer-level model.
module tb_apb_master_bridge;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       proc_start, proc_write;
    logic [1:0] proc_sel;
    logic [7:0] proc_addr, proc_wdata, proc_wait_cycles;
    logic [7:0] proc_rdata;
    logic       proc_ready, proc_error, proc_busy;
    logic       apb_write, apb_enable, apb_ready;
    logic [1:0] apb_sel;
    logic [7:0] apb_addr, apb_wdata, apb_wait_cycles, apb_rdata;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [7:0] last_rd  = 8'h00;

    apb_master_bridge #(
        .DATA_W(8), .ADDR_W(8), .SEL_W(2), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .proc_start(proc_start), .proc_write(proc_write), .proc_sel(proc_sel),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_wait_cycles(proc_wait_cycles),
        .proc_rdata(proc_rdata), .proc_ready(proc_ready), .proc_error(proc_error),
        .proc_busy(proc_busy), .apb_write(apb_write), .apb_sel(apb_sel),
        .apb_addr(apb_addr), .apb_wdata(apb_wdata), .apb_enable(apb_enable),
        .apb_wait_cycles(apb_wait_cycles), .apb_ready(apb_ready), .apb_rdata(apb_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       wr;
        logic [1:0] sel;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] waitc;
        int         sw;
        logic [7:0] srd;
        int         exp_lat;
        logic       exp_err;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at=%0d got=%0h want=%0h", name, k, got, exp);
        end
    endtask

    // Transfer-level model: cycles to proc_ready, ACCESS cycle count, error and returned data.
    function automatic void model(input logic wr, input logic [1:0] sel, input int sw,
                                  input logic [7:0] srd, output int lat, output int acc,
                                  output logic err, output logic [7:0] rd);
        if ($countones(sel) != 1) begin
            lat = 1; acc = 0; err = 1'b1; rd = 8'h00;
        end else if (sw + 1 <= TO) begin
            acc = sw + 1; lat = acc + 2; err = 1'b0; rd = wr ? 8'h00 : srd;
        end else begin
            acc = TO; lat = TO + 2; err = 1'b1; rd = 8'h00;
        end
    endfunction

    task automatic bus_check(input string tag, input int k, input logic busy, input logic rdy,
                             input logic err, input logic [7:0] rdv, input logic act,
                             input logic en, input logic wr, input logic [1:0] sel,
                             input logic [7:0] addr, input logic [7:0] wdata, input logic [7:0] waitc);
        check({tag, ".busy"},   k, proc_busy,       busy);
        check({tag, ".ready"},  k, proc_ready,      rdy);
        check({tag, ".error"},  k, proc_error,      err);
        check({tag, ".rdata"},  k, proc_rdata,      rdv);
        check({tag, ".psel"},   k, apb_sel,         act ? sel : 2'b00);
        check({tag, ".penable"},k, apb_enable,      en);
        check({tag, ".pwrite"}, k, apb_write,       act ? wr : 1'b0);
        check({tag, ".paddr"},  k, apb_addr,        act ? addr : 8'h00);
        check({tag, ".pwdata"}, k, apb_wdata,       act ? wdata : 8'h00);
        check({tag, ".pwait"},  k, apb_wait_cycles, act ? waitc : 8'h00);
    endtask

    task automatic idle_check(input string tag, input int k);
        bus_check(tag, k, 1'b0, 1'b0, 1'b0, last_rd, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    endtask

    // Drives one transfer from its IDLE cycle to DONE; a slave model answers PREADY after sw waits.
    task automatic run_txn(input string tag, input logic wr, input logic [1:0] sel,
                           input logic [7:0] addr, input logic [7:0] wdata, input logic [7:0] waitc,
                           input int sw, input logic [7:0] srd, input logic hold,
                           output int lat, output logic err, output logic [7:0] rd, output int rcyc);
        int         m_lat, m_acc, acc_seen;
        logic       m_err, legal, done, act, inacc, seen;
        logic [7:0] m_rd;
        model(wr, sel, sw, srd, m_lat, m_acc, m_err, m_rd);
        legal = ($countones(sel) == 1);
        @(negedge clk);
        idle_check({tag, ".idle"}, 0);
        proc_write = wr; proc_sel = sel; proc_addr = addr; proc_wdata = wdata;
        proc_wait_cycles = waitc; proc_start = 1'b1; apb_ready = 1'b0;
        lat = -1; err = 1'b0; rd = 8'h00; rcyc = 0; acc_seen = 0; seen = 1'b0;
        for (int k = 1; k <= 12 && !seen; k++) begin
            @(negedge clk);
            done  = (k == m_lat);
            act   = legal && (k < m_lat);
            inacc = legal && (k >= 2) && (k < m_lat);
            bus_check(tag, k, k <= m_lat, done, done && m_err, done ? m_rd : last_rd,
                      act, inacc, wr, sel, addr, wdata, waitc);
            if (done) last_rd = m_rd;
            if (proc_ready) begin
                seen = 1'b1; lat = k; err = proc_error; rd = proc_rdata; rcyc = cyc;
            end else begin
                if (apb_enable) acc_seen++;
                apb_ready  = apb_enable && (acc_seen == sw + 1);
                apb_rdata  = apb_ready ? srd : 8'($urandom);
                proc_start = hold ? 1'b1 : 1'($urandom);
                proc_write = 1'($urandom);
                proc_sel   = 2'($urandom);
                proc_addr  = 8'($urandom);
                proc_wdata = 8'($urandom);
                proc_wait_cycles = 8'($urandom);
            end
        end
        apb_ready  = 1'b0;
        proc_start = hold;
        if (!seen) check({tag, ".ready_within_budget"}, 12, 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog at=%0d got=running want=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int         lat, rc, prev, m_lat, m_acc, sw;
        logic       err, m_err, wr;
        logic [1:0] sel;
        logic [7:0] rd, m_rd, srd;

        tbl[0] = '{1'b1, 2'b01, 8'h10, 8'hA5, 8'h00, 0,  8'h00, 3, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 2'b10, 8'h22, 8'h00, 8'h03, 3,  8'h5C, 6, 1'b0, 8'h5C};
        tbl[2] = '{1'b0, 2'b01, 8'h33, 8'h00, 8'h00, 99, 8'hEE, 6, 1'b1, 8'h00};
        tbl[3] = '{1'b1, 2'b00, 8'h44, 8'h11, 8'h00, 0,  8'h00, 1, 1'b1, 8'h00};
        tbl[4] = '{1'b0, 2'b11, 8'h55, 8'h00, 8'h02, 0,  8'h77, 1, 1'b1, 8'h00};
        tbl[5] = '{1'b0, 2'b01, 8'h66, 8'h00, 8'h03, 3,  8'hC3, 6, 1'b0, 8'hC3};
        tbl[6] = '{1'b0, 2'b10, 8'h77, 8'h00, 8'h04, 4,  8'h3C, 6, 1'b1, 8'h00};
        tbl[7] = '{1'b0, 2'b10, 8'h88, 8'h00, 8'h00, 0,  8'h99, 3, 1'b0, 8'h99};
        tbl[8] = '{1'b1, 2'b01, 8'h99, 8'h5A, 8'h01, 1,  8'hFF, 4, 1'b0, 8'h00};

        reset = 1'b1; proc_start = 1'b0; proc_write = 1'b0; proc_sel = 2'b00;
        proc_addr = 8'h00; proc_wdata = 8'h00; proc_wait_cycles = 8'h00;
        apb_ready = 1'b0; apb_rdata = 8'h00;
        @(negedge clk);
        idle_check("reset", 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].sel, tbl[i].addr, tbl[i].wdata,
                    tbl[i].waitc, tbl[i].sw, tbl[i].srd, 1'b0, lat, err, rd, rc);
            check($sformatf("vec%0d.latency", i), i, lat, tbl[i].exp_lat);
            check($sformatf("vec%0d.err", i),     i, err, tbl[i].exp_err);
            check($sformatf("vec%0d.rd", i),      i, rd,  tbl[i].exp_rd);
        end

        // proc_start held high: one completion every 4 cycles, busy-time starts ignored.
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            run_txn("hold", i[0], i[0] ? 2'b10 : 2'b01, 8'(8'h20 + i), 8'(8'h30 + i), 8'h00,
                    0, 8'(8'hB0 + i), (i < 4), lat, err, rd, rc);
            if (i > 0) check("hold.period", i, rc - prev, 4);
            prev = rc;
        end

        // Reset in the middle of ACCESS.
        @(negedge clk);
        proc_write = 1'b0; proc_sel = 2'b01; proc_addr = 8'h4C; proc_wait_cycles = 8'h05;
        proc_start = 1'b1; apb_ready = 1'b0;
        @(negedge clk);
        proc_start = 1'b0;
        check("rst.setup_psel", 1, apb_sel, 2'b01);
        @(negedge clk);
        check("rst.access_penable", 2, apb_enable, 1'b1);
        reset = 1'b1;
        #1;
        last_rd = 8'h00;
        idle_check("rst.async", 2);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst.no_ready", k, proc_ready, 1'b0);
            check("rst.no_busy",  k, proc_busy,  1'b0);
        end
        run_txn("rst.next", 1'b0, 2'b10, 8'h5D, 8'h00, 8'h01, 0, 8'h7E, 1'b0, lat, err, rd, rc);
        check("rst.next.latency", 0, lat, 3);
        check("rst.next.rd",      0, rd,  8'h7E);

        for (int i = 0; i < 80; i++) begin
            int r;
            r   = $urandom_range(0, 9);
            sel = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
            wr  = 1'($urandom);
            sw  = $urandom_range(0, 6);
            srd = 8'($urandom);
            model(wr, sel, sw, srd, m_lat, m_acc, m_err, m_rd);
            run_txn("rand", wr, sel, 8'($urandom), 8'($urandom), 8'($urandom), sw, srd, 1'b0,
                    lat, err, rd, rc);
            check("rand.latency", i, lat, m_lat);
            check("rand.err",     i, err, m_err);
            check("rand.rd",      i, rd,  m_rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
